// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: one valid/ready input stream steered to two output
// branches by select_i. Each branch owns an independent 2-entry FIFO, so a
// stalled consumer never blocks words already routed to the other branch.
//
// Handshake rules:
//   - A transfer happens on a rising edge when valid and ready are both 1.
//   - The input side:
//     - ready_o depends only on the count of the branch named by select_i.
//     - ready_o never looks at valid_i, ready0_i or ready1_i.
//     - A full branch is not bypassed by a same-cycle pop.
//   - The output side:
//     - valid_k_o is 1 exactly when branch k holds a word.
//     - data_k_o shows the head word, or zero when the branch is empty.
//     - Both come straight from registers, so there is no path from the
//       input to any output.
module demux_1to2_buf #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic            valid_i,
  input  logic            select_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic            valid0_o,
  input  logic            ready0_i,
  output logic [size-1:0] data1_o,
  output logic            valid1_o,
  input  logic            ready1_i
);

  // Per-branch storage, occupancy and 1-bit wrapping pointers
  logic [size-1:0] r_mem [2][2];
  logic [1:0]      r_cnt [2];
  logic            r_rd  [2];
  logic            r_wr  [2];

  logic            w_ready;
  logic [1:0]      w_push;
  logic [1:0]      w_pop;
  logic [1:0]      w_ready_k;

  // Input acceptance and per-branch push/pop decisions for this cycle
  always_comb begin
    w_ready_k = {ready1_i, ready0_i};
    w_ready   = select_i ? (r_cnt[1] != 2'd2) : (r_cnt[0] != 2'd2);
    w_push    = 2'b00;
    w_pop     = 2'b00;
    w_push[0] = valid_i & w_ready & ~select_i;
    w_push[1] = valid_i & w_ready & select_i;
    w_pop[0]  = (r_cnt[0] != 2'd0) & w_ready_k[0];
    w_pop[1]  = (r_cnt[1] != 2'd0) & w_ready_k[1];
  end

  assign ready_o  = w_ready;
  assign valid0_o = (r_cnt[0] != 2'd0);
  assign valid1_o = (r_cnt[1] != 2'd0);
  assign data0_o  = valid0_o ? r_mem[0][r_rd[0]] : '0;
  assign data1_o  = valid1_o ? r_mem[1][r_rd[1]] : '0;

  // FIFO state update; reset discards everything, including words in flight
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < 2; k++) begin
        r_cnt[k]    <= 2'd0;
        r_rd[k]     <= 1'b0;
        r_wr[k]     <= 1'b0;
        r_mem[k][0] <= '0;
        r_mem[k][1] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_push[k]) begin
          r_mem[k][r_wr[k]] <= data_i;
          r_wr[k]           <= ~r_wr[k];
        end
        if (w_pop[k]) begin
          r_rd[k] <= ~r_rd[k];
        end
        if (w_push[k] && !w_pop[k]) begin
          r_cnt[k] <= r_cnt[k] + 2'd1;
        end else if (w_pop[k] && !w_push[k]) begin
          r_cnt[k] <= r_cnt[k] - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Testbench for demux_1to2_buf: directed scenarios plus a long random run,
// all checked every cycle against a queue-based model of the two branches.
module tb_demux_1to2_buf;
  localparam int W = 32;

  // Clock and reset
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         valid_i = 1'b0;
  logic         select_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] data0_o;
  logic         valid0_o;
  logic         ready0_i = 1'b0;
  logic [W-1:0] data1_o;
  logic         valid1_o;
  logic         ready1_i = 1'b0;

  demux_1to2_buf #(.size(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .select_i (select_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i)
  );

  // Scoreboard: one expected queue per branch, head = next word out
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_acc0   = 0;
  int n_acc1   = 0;
  int n_out0   = 0;
  int n_out1   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Compare every DUT output against the model state for the current cycle
  task automatic model_check();
    int sel_cnt;
    sel_cnt = select_i ? exp_q1.size() : exp_q0.size();
    check("valid0", {63'd0, valid0_o}, {63'd0, exp_q0.size() != 0});
    check("valid1", {63'd0, valid1_o}, {63'd0, exp_q1.size() != 0});
    check("data0", {32'd0, data0_o}, {32'd0, (exp_q0.size() != 0) ? exp_q0[0] : 32'd0});
    check("data1", {32'd0, data1_o}, {32'd0, (exp_q1.size() != 0) ? exp_q1[0] : 32'd0});
    check("ready", {63'd0, ready_o}, {63'd0, sel_cnt < 2});
  endtask

  // Driver: apply inputs after a falling edge, check, advance one rising
  // edge, update the model, and return at the next falling edge.
  task automatic cycle(input logic rst, input logic v, input logic sel,
                       input logic [W-1:0] d, input logic r0, input logic r1,
                       output logic rdy_seen);
    logic push, pop0, pop1;
    rst_i = rst; valid_i = v; select_i = sel; data_i = d;
    ready0_i = r0; ready1_i = r1;
    #1;
    model_check();
    rdy_seen = ready_o;
    push = rst && v && ((sel ? exp_q1.size() : exp_q0.size()) < 2);
    pop0 = rst && (exp_q0.size() != 0) && r0;
    pop1 = rst && (exp_q1.size() != 0) && r1;
    @(posedge clk_i);
    if (!rst) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (pop0) begin void'(exp_q0.pop_front()); n_out0++; end
      if (pop1) begin void'(exp_q1.pop_front()); n_out1++; end
      if (push) begin
        if (sel) begin exp_q1.push_back(d); n_acc1++; end
        else     begin exp_q0.push_back(d); n_acc0++; end
      end
    end
    @(negedge clk_i);
  endtask

  logic rdy;

  initial begin
    @(negedge clk_i);
    // Reset state
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);
    check("rst_valid0_lit", {63'd0, valid0_o}, 64'd0);
    check("rst_data0_lit", {32'd0, data0_o}, 64'd0);

    // Single word through branch 0
    cycle(1'b1, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b1, rdy);
    check("t1_valid0_lit", {63'd0, valid0_o}, 64'd1);
    check("t1_data0_lit", {32'd0, data0_o}, 64'h11111111);
    check("t1_valid1_lit", {63'd0, valid1_o}, 64'd0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);
    check("t1_drained_lit", {63'd0, valid0_o}, 64'd0);

    // Backpressure on branch 0, third word redirected to branch 1
    cycle(1'b1, 1'b1, 1'b0, 32'hA0, 1'b0, 1'b1, rdy);
    check("t2_rdy0_lit", {63'd0, rdy}, 64'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'hA1, 1'b0, 1'b1, rdy);
    check("t2_rdy1_lit", {63'd0, rdy}, 64'd1);
    cycle(1'b1, 1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, rdy);
    check("t2_rdy2_lit", {63'd0, rdy}, 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'hA2, 1'b0, 1'b0, rdy);
    check("t2_rdy_sel1_lit", {63'd0, rdy}, 64'd1);
    check("t2_data1_lit", {32'd0, data1_o}, 64'hA2);
    check("t2_head_lit", {32'd0, data0_o}, 64'hA0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);
    check("t2_second_lit", {32'd0, data0_o}, 64'hA1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);
    check("t2_empty_lit", {63'd0, valid0_o}, 64'd0);

    // Push and pop in the same cycle at count 1
    cycle(1'b1, 1'b1, 1'b0, 32'hB0, 1'b0, 1'b0, rdy);
    cycle(1'b1, 1'b1, 1'b0, 32'hB1, 1'b1, 1'b0, rdy);
    check("t3_valid0_lit", {63'd0, valid0_o}, 64'd1);
    check("t3_data0_lit", {32'd0, data0_o}, 64'hB1);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);
    check("t3_done_lit", {63'd0, valid0_o}, 64'd0);

    // Alternating select at full rate
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, i[0], W'(i), 1'b1, 1'b1, rdy);
      check("t4_rdy_lit", {63'd0, rdy}, 64'd1);
      check("t4_word_lit", {32'd0, (i[0] ? data1_o : data0_o)}, 64'(i));
    end
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);

    // Fill both branches, then reset mid-stream
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, i[0], 32'hC0 + W'(i), 1'b0, 1'b0, rdy);
    end
    cycle(1'b0, 1'b1, 1'b0, 32'hEE, 1'b1, 1'b1, rdy);
    check("t5_valid0_lit", {63'd0, valid0_o}, 64'd0);
    check("t5_valid1_lit", {63'd0, valid1_o}, 64'd0);
    check("t5_data1_lit", {32'd0, data1_o}, 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'hD0, 1'b0, 1'b0, rdy);
    check("t5_rdy_lit", {63'd0, rdy}, 64'd1);
    check("t5_first_lit", {32'd0, data1_o}, 64'hD0);

    // Random traffic with occasional reset
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 499) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), W'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), rdy);
    end
    model_check();
    check("words_delivered", 64'(n_out0 + n_out1 + exp_q0.size() + exp_q1.size()) <= 64'(n_acc0 + n_acc1), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
